// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// mmio_pkg: address map, FSM states and access-legality check for the MMIO initiator
// Rev 1.0
// ============================================================================
package mmio_pkg;

  localparam logic [3:0] ADDR_KEYPAD  = 4'h0;
  localparam logic [3:0] ADDR_DISPLAY = 4'h4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Keypad is read-only, display is write-only; everything else is unmapped.
  function automatic logic access_ok(input logic [31:0] addr, input logic we);
    return we ? (addr == {28'd0, ADDR_DISPLAY}) : (addr == {28'd0, ADDR_KEYPAD});
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_bus_initiator_if.sv
`default_nettype none
// ============================================================================
// mmio_bus_initiator_if: CPU request handshake plus serial peripheral port
// Rev 1.0
// ============================================================================
interface mmio_bus_initiator_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic              error;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] address;
  logic              din;
  logic              writeEnable;
  logic              dout;

  modport master (
    input  req, we, addr, wdata, dout,
    output busy, done, error, rdata, address, din, writeEnable
  );

  modport slave (
    output req, we, addr, wdata, dout,
    input  busy, done, error, rdata, address, din, writeEnable
  );
endinterface
`default_nettype wire

// File: rtl/mmio_serdes.sv
`default_nettype none
// ============================================================================
// mmio_serdes: bit counter, LSB-first write shifter and read shadow register
// Rev 1.0
// ============================================================================
module mmio_serdes #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              load_wr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              step_i,
  input  logic              dout_i,
  output logic              last_o,
  output logic              din_o,
  output logic [DATA_W-1:0] shadow_d_o
);
  localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] wsh_q, wsh_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;

  assign last_o     = (cnt_q == CNT_LAST);
  assign din_o      = wsh_q[0];
  // Exposes the in-flight bit so the final sample can be captured on the exit edge.
  assign shadow_d_o = shadow_d;

  always_comb begin
    cnt_d    = cnt_q;
    wsh_d    = wsh_q;
    shadow_d = shadow_q;
    if (load_i) begin
      cnt_d = '0;
      if (load_wr_i) begin
        wsh_d = wdata_i;
      end
    end else if (step_i) begin
      cnt_d            = last_o ? '0 : cnt_q + CNT_W'(1);
      wsh_d            = wsh_q >> 1;
      shadow_d[cnt_q]  = dout_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      wsh_q    <= '0;
      shadow_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      wsh_q    <= wsh_d;
      shadow_q <= shadow_d;
    end
  end
endmodule
`default_nettype wire

// File: rtl/mmio_bus_initiator.sv
`default_nettype none
// ============================================================================
// mmio_bus_initiator: serialises CPU loads/stores onto the 1-bit peripheral port
// Rev 1.0
// ============================================================================
module mmio_bus_initiator #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mmio_bus_initiator_if.master bus
);
  import mmio_pkg::*;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        lat_q, lat_d;
  logic              legal;
  logic              load;
  logic              step;
  logic              last;
  logic              din;
  logic [DATA_W-1:0] shadow_nxt;

  assign legal = access_ok(32'(bus.addr), bus.we);
  assign step  = (state_q == XFER);

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    err_d     = err_q;
    address_d = address_q;
    rdata_d   = rdata_q;
    lat_d     = lat_q;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          err_d = !legal;
          if (!legal) begin
            state_d = DONE;
          end else begin
            load      = 1'b1;
            we_d      = bus.we;
            address_d = bus.addr;
            lat_d     = '0;
            state_d   = (!bus.we && READ_LAT > 0) ? SETUP : XFER;
          end
        end
      end
      SETUP: begin
        if (lat_q == 2'(READ_LAT - 1)) begin
          state_d = XFER;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      XFER: begin
        if (last) begin
          state_d = DONE;
          if (!we_q) begin
            rdata_d = shadow_nxt;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      address_q <= '0;
      rdata_q   <= '0;
      lat_q     <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      err_q     <= err_d;
      address_q <= address_d;
      rdata_q   <= rdata_d;
      lat_q     <= lat_d;
    end
  end

  mmio_serdes #(.DATA_W(DATA_W)) u_serdes (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .load_wr_i  (bus.we),
    .wdata_i    (bus.wdata),
    .step_i     (step),
    .dout_i     (bus.dout),
    .last_o     (last),
    .din_o      (din),
    .shadow_d_o (shadow_nxt)
  );

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.error       = (state_q == DONE) && err_q;
  assign bus.rdata       = rdata_q;
  assign bus.address     = address_q;
  assign bus.din         = din;
  assign bus.writeEnable = step && we_q;
endmodule
`default_nettype wire

// File: doc/mmio_bus_initiator.md
Name: mmio_bus_initiator

Overview:
Bus-side initiator that drives the peripheral controller's memory-mapped port (address, din, writeEnable, dout) on behalf of the CPU load/store unit. It accepts one DATA_W-bit request at a time over a req/busy/done handshake. Because the peripheral data path is 1 bit wide, it serialises each transfer LSB first over DATA_W cycles. It also rejects accesses to unmapped or wrong-direction addresses.

Parameters:
ADDR_W, 4, width of the peripheral address bus.
DATA_W, 8, bits per transfer; legal range 1..32.
READ_LAT, 1, cycles from address presentation to the first valid dout bit; legal range 0..3.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
req  in  1  CPU request; sampled only in IDLE.
we  in  1  1 = write, 0 = read; sampled with req.
addr  in  ADDR_W  target peripheral address; sampled with req.
wdata  in  DATA_W  write data; sampled with req.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when a transaction ends.
error  out  1  valid with done; 1 = rejected access.
rdata  out  DATA_W  read result; updated only by a successful read.
address  out  ADDR_W  to the peripheral controller.
din  out  1  serial write bit to the peripheral controller.
writeEnable  out  1  write strobe to the peripheral controller.
dout  in  1  serial read bit from the peripheral controller.

Behaviour:
- Reset values: busy=0, done=0, error=0, rdata=0, address=0, din=0, writeEnable=0; state=IDLE.
- Reset asserted mid-transaction abandons it at the next edge. No done pulse is produced, and writeEnable is low in the cycle after reset is sampled.
- Address map: 0x0 is the keypad and is read-only; 0x4 is the display and is write-only.
- The following are rejected: any other address, a write to 0x0, or a read from 0x4.
- Rejected accesses go IDLE -> DONE with error=1 and no bus activity: address, din and writeEnable are unchanged, and rdata is unchanged.
- States:
  - IDLE: busy=0. When req=1, latch we, addr and wdata, then go to SETUP (read with READ_LAT>0), XFER (write, or read with READ_LAT=0), or DONE (rejected access). address is driven from the latched addr starting the next cycle.
  - SETUP: writeEnable=0. Stay for exactly READ_LAT cycles, then go to XFER.
  - XFER: a bit counter runs from 0 to DATA_W-1; leave after exactly DATA_W cycles.
    - Write: din = bit[cnt] of the latched wdata and writeEnable=1 in every XFER cycle.
    - Read: dout is sampled at the end of each XFER cycle into bit[cnt] of a shadow register. rdata is loaded from the shadow register when entering DONE.
  - DONE: done=1 for one cycle, error as determined above, writeEnable=0, then go to IDLE.
- Latency, with req accepted at edge 0:
  - Write: XFER occupies cycles 1..DATA_W; done in cycle DATA_W+1.
  - Read: SETUP occupies 1..READ_LAT; XFER occupies READ_LAT+1..READ_LAT+DATA_W; done in cycle READ_LAT+DATA_W+1.
  - Rejected access: done in cycle 1.
- req while busy=1 is ignored and not queued.
- req held high continuously: the next transaction is accepted on the IDLE cycle after DONE, so there is a minimum of one idle cycle between transactions.
- writeEnable is never high outside XFER of an accepted write.

Decomposition:
- Shared package (mmio_pkg):
  - address constants ADDR_KEYPAD=4'h0 and ADDR_DISPLAY=4'h4;
  - state enum IDLE/SETUP/XFER/DONE;
  - an access-legality function taking (addr, we).
- One natural sub-module, mmio_serdes. It holds the bit counter, the write shift register and the read shadow register, with load/step/last ports. The FSM stays in the top module.

Test Plan:
- Write: DATA_W=8, READ_LAT=1, req with we=1, addr=0x4, wdata=0xA5 at edge 0 -> writeEnable=1 in cycles 1..8; din=1,0,1,0,0,1,0,1; done=1 and error=0 in cycle 9; busy=0 in cycle 10.
- Read: req with we=0, addr=0x0; dout model presents 0x3C LSB first in cycles 2..9 -> writeEnable stays 0; done in cycle 10 with rdata=0x3C and error=0.
- Illegal reads: read from 0x4, and separately read from 0x7 -> done with error=1 in cycle 1; writeEnable never high; rdata keeps its previous value 0x3C.
- Busy filtering: second req (write 0x4, 0xFF) pulsed in cycle 3 of an active write -> ignored; exactly one done; din sequence matches the first wdata only.
- Reset mid-write: reset=1 during cycle 4 of a write -> all outputs at reset values from the next cycle; no done pulse afterwards.
- Held req: req held high with write 0x4, 0x01 -> first done in cycle 9; next XFER starts in cycle 11; done pulses are 10 cycles apart.
